// File: rtl/conv_pkg.sv
// Shared constants and types for the conv subsystem result SRAM path.
// Widths, read owner encoding and the registered read owner tag.
package conv_pkg;

    localparam int CONV_ADDR_WIDTH = 9;
    localparam int CONV_RD_WIDTH   = 128;
    localparam int CONV_WR_WIDTH   = 64;

    localparam logic OWN_HOST = 1'b0;
    localparam logic OWN_ENG  = 1'b1;

    typedef struct packed {
        logic vld;
        logic own;
    } rd_tag_t;

endpackage

// File: rtl/conv_arb_port.sv
// Two-requester arbiter: engine priority, host starvation promotion.
// Ports: clk, rst_n, excl_i, h/e_req_i in; h/e_gnt_o, starve_o out.
module conv_arb_port #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic excl_i,
    input  logic h_req_i,
    input  logic e_req_i,
    output logic h_gnt_o,
    output logic e_gnt_o,
    output logic starve_o
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       force_h;

    // Promotion only when saturated and the engine is not exclusive.
    assign force_h = (cnt_q == MAX_W) && !excl_i;

    // Grants are gated by rst_n so outputs stay low during reset.
    assign h_gnt_o  = rst_n && h_req_i && (!e_req_i || force_h);
    assign e_gnt_o  = rst_n && e_req_i && !(h_req_i && force_h);
    assign starve_o = h_gnt_o && e_req_i;

    always_comb begin
        cnt_d = cnt_q;
        if (h_gnt_o) begin
            cnt_d = '0;
        end else if (h_req_i && !excl_i && (cnt_q != MAX_W)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_sram_arbiter.sv
// Host/engine arbiter for the conv result SRAM (1R + 1W ports).
// Ports: host/engine rd/wr req+addr+data in, gnt/rd_valid out, SRAM side.
module conv_sram_arbiter
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = CONV_ADDR_WIDTH,
    parameter int RD_WIDTH   = CONV_RD_WIDTH,
    parameter int WR_WIDTH   = CONV_WR_WIDTH,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  eng_excl,
    input  logic                  h_rd_req,
    input  logic [ADDR_WIDTH-1:0] h_rd_addr,
    input  logic                  e_rd_req,
    input  logic [ADDR_WIDTH-1:0] e_rd_addr,
    output logic                  h_rd_gnt,
    output logic                  e_rd_gnt,
    output logic                  h_rd_valid,
    output logic                  e_rd_valid,
    output logic [RD_WIDTH-1:0]   rd_data,
    input  logic                  h_wr_req,
    input  logic [ADDR_WIDTH-1:0] h_wr_addr,
    input  logic [WR_WIDTH-1:0]   h_wr_data,
    input  logic                  e_wr_req,
    input  logic [ADDR_WIDTH-1:0] e_wr_addr,
    input  logic [WR_WIDTH-1:0]   e_wr_data,
    output logic                  h_wr_gnt,
    output logic                  e_wr_gnt,
    output logic                  sram_re,
    output logic [ADDR_WIDTH-1:0] sram_addr_r,
    input  logic [RD_WIDTH-1:0]   sram_dout,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr_w,
    output logic [WR_WIDTH-1:0]   sram_din,
    output logic                  h_starve_evt
);

    logic    rd_starve;
    logic    wr_starve;
    rd_tag_t tag_q;
    rd_tag_t tag_d;

    conv_arb_port #(.MAX_WAIT(MAX_WAIT)) u_rd_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .excl_i   (eng_excl),
        .h_req_i  (h_rd_req),
        .e_req_i  (e_rd_req),
        .h_gnt_o  (h_rd_gnt),
        .e_gnt_o  (e_rd_gnt),
        .starve_o (rd_starve)
    );

    conv_arb_port #(.MAX_WAIT(MAX_WAIT)) u_wr_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .excl_i   (eng_excl),
        .h_req_i  (h_wr_req),
        .e_req_i  (e_wr_req),
        .h_gnt_o  (h_wr_gnt),
        .e_gnt_o  (e_wr_gnt),
        .starve_o (wr_starve)
    );

    assign h_starve_evt = rd_starve || wr_starve;
    assign sram_re      = h_rd_gnt || e_rd_gnt;
    assign sram_we      = h_wr_gnt || e_wr_gnt;

    always_comb begin
        sram_addr_r = '0;
        unique case (1'b1)
            h_rd_gnt: sram_addr_r = h_rd_addr;
            e_rd_gnt: sram_addr_r = e_rd_addr;
            default:  sram_addr_r = '0;
        endcase
    end

    always_comb begin
        sram_addr_w = '0;
        sram_din    = '0;
        unique case (1'b1)
            h_wr_gnt: begin
                sram_addr_w = h_wr_addr;
                sram_din    = h_wr_data;
            end
            e_wr_gnt: begin
                sram_addr_w = e_wr_addr;
                sram_din    = e_wr_data;
            end
            default: begin
                sram_addr_w = '0;
                sram_din    = '0;
            end
        endcase
    end

    always_comb begin
        tag_d.vld = sram_re;
        tag_d.own = e_rd_gnt ? OWN_ENG : OWN_HOST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign h_rd_valid = tag_q.vld && (tag_q.own == OWN_HOST);
    assign e_rd_valid = tag_q.vld && (tag_q.own == OWN_ENG);
    // Zero the shared bus when no read is returning.
    assign rd_data    = tag_q.vld ? sram_dout : '0;

endmodule

// File: tb/tb_conv_sram_arbiter.sv
// Directed self-checking bench for conv_sram_arbiter with an SRAM model.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_conv_sram_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         eng_excl = 1'b0;
    logic         h_rd_req = 1'b0;
    logic [8:0]   h_rd_addr = '0;
    logic         e_rd_req = 1'b0;
    logic [8:0]   e_rd_addr = '0;
    logic         h_rd_gnt, e_rd_gnt, h_rd_valid, e_rd_valid;
    logic [127:0] rd_data;
    logic         h_wr_req = 1'b0;
    logic [8:0]   h_wr_addr = '0;
    logic [63:0]  h_wr_data = '0;
    logic         e_wr_req = 1'b0;
    logic [8:0]   e_wr_addr = '0;
    logic [63:0]  e_wr_data = '0;
    logic         h_wr_gnt, e_wr_gnt;
    logic         sram_re, sram_we;
    logic [8:0]   sram_addr_r, sram_addr_w;
    logic [127:0] sram_dout = '0;
    logic [63:0]  sram_din;
    logic         h_starve_evt;

    logic [127:0] mem [512];
    int checks = 0;
    int errors = 0;

    localparam logic [63:0] WB = 64'hB0B1_B2B3_B4B5_B6B7;

    always #5 clk = ~clk;

    conv_sram_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .eng_excl(eng_excl),
        .h_rd_req(h_rd_req), .h_rd_addr(h_rd_addr),
        .e_rd_req(e_rd_req), .e_rd_addr(e_rd_addr),
        .h_rd_gnt(h_rd_gnt), .e_rd_gnt(e_rd_gnt),
        .h_rd_valid(h_rd_valid), .e_rd_valid(e_rd_valid),
        .rd_data(rd_data),
        .h_wr_req(h_wr_req), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
        .e_wr_req(e_wr_req), .e_wr_addr(e_wr_addr), .e_wr_data(e_wr_data),
        .h_wr_gnt(h_wr_gnt), .e_wr_gnt(e_wr_gnt),
        .sram_re(sram_re), .sram_addr_r(sram_addr_r), .sram_dout(sram_dout),
        .sram_we(sram_we), .sram_addr_w(sram_addr_w), .sram_din(sram_din),
        .h_starve_evt(h_starve_evt)
    );

    function automatic logic [127:0] line(int a);
        return {4{16'hC0DE, 16'(a)}};
    endfunction

    // Read-before-write SRAM: reads see the pre-edge contents.
    always @(posedge clk) begin
        if (sram_re) sram_dout <= mem[sram_addr_r];
        if (sram_we) mem[sram_addr_w] <= {64'h0, sram_din};
    end

    task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(string tag);
        chk({tag, ".hrg"}, 128'(h_rd_gnt), 0);
        chk({tag, ".erg"}, 128'(e_rd_gnt), 0);
        chk({tag, ".hrv"}, 128'(h_rd_valid), 0);
        chk({tag, ".erv"}, 128'(e_rd_valid), 0);
        chk({tag, ".rdd"}, rd_data, 0);
        chk({tag, ".hwg"}, 128'(h_wr_gnt), 0);
        chk({tag, ".ewg"}, 128'(e_wr_gnt), 0);
        chk({tag, ".re"}, 128'(sram_re), 0);
        chk({tag, ".ar"}, 128'(sram_addr_r), 0);
        chk({tag, ".we"}, 128'(sram_we), 0);
        chk({tag, ".aw"}, 128'(sram_addr_w), 0);
        chk({tag, ".din"}, 128'(sram_din), 0);
        chk({tag, ".stv"}, 128'(h_starve_evt), 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = line(i);

        // Reset state
        @(negedge clk);
        chk_idle("rst");
        rst_n = 1'b1;

        // Solo host read
        step();
        h_rd_req = 1'b1; h_rd_addr = 9'h0F0;
        @(negedge clk);
        chk("solo.hg", 128'(h_rd_gnt), 1);
        chk("solo.eg", 128'(e_rd_gnt), 0);
        chk("solo.ar", 128'(sram_addr_r), 128'h0F0);
        step();
        h_rd_req = 1'b0;
        @(negedge clk);
        chk("solo.hv", 128'(h_rd_valid), 1);
        chk("solo.ev", 128'(e_rd_valid), 0);
        chk("solo.d", rd_data, line(9'h0F0));

        // Read contention: host forced on cycles 4 and 9
        step();
        h_rd_req = 1'b1; h_rd_addr = 9'h011;
        e_rd_req = 1'b1; e_rd_addr = 9'h022;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("cont.hg%0d", c), 128'(h_rd_gnt),
                128'(c == 4 || c == 9));
            chk($sformatf("cont.eg%0d", c), 128'(e_rd_gnt),
                128'(c != 4 && c != 9));
            chk($sformatf("cont.sv%0d", c), 128'(h_starve_evt),
                128'(c == 4 || c == 9));
            chk($sformatf("cont.ar%0d", c), 128'(sram_addr_r),
                (c == 4 || c == 9) ? 128'h011 : 128'h022);
            if (c == 5) begin
                chk("cont.hv5", 128'(h_rd_valid), 1);
                chk("cont.d5", rd_data, line(9'h011));
            end
            step();
        end
        h_rd_req = 1'b0; e_rd_req = 1'b0;

        // Write contention, saturate, then exclusive for 20 cycles
        step();
        h_wr_req = 1'b1; h_wr_addr = 9'h1F1; h_wr_data = 64'h1111;
        e_wr_req = 1'b1; e_wr_addr = 9'h1F0; e_wr_data = 64'h2222;
        for (int c = 0; c < 24; c++) begin
            eng_excl = (c >= 4);
            @(negedge clk);
            chk($sformatf("excl.eg%0d", c), 128'(e_wr_gnt), 1);
            chk($sformatf("excl.hg%0d", c), 128'(h_wr_gnt), 0);
            step();
        end
        eng_excl = 1'b0;
        @(negedge clk);
        chk("excl.hg_after", 128'(h_wr_gnt), 1);
        chk("excl.eg_after", 128'(e_wr_gnt), 0);
        chk("excl.sv_after", 128'(h_starve_evt), 1);
        chk("excl.aw", 128'(sram_addr_w), 128'h1F1);
        chk("excl.din", 128'(sram_din), 128'h1111);
        step();
        h_wr_req = 1'b0; e_wr_req = 1'b0;

        // Same-address read and write
        step();
        h_wr_req = 1'b1; h_wr_addr = 9'h180; h_wr_data = WB;
        e_rd_req = 1'b1; e_rd_addr = 9'h180;
        @(negedge clk);
        chk("raw.wg", 128'(h_wr_gnt), 1);
        chk("raw.rg", 128'(e_rd_gnt), 1);
        chk("raw.sv", 128'(h_starve_evt), 0);
        step();
        h_wr_req = 1'b0;
        @(negedge clk);
        chk("raw.old", rd_data, line(9'h180));
        step();
        e_rd_req = 1'b0;
        @(negedge clk);
        chk("raw.new", rd_data, {64'h0, WB});

        // Pipelined engine reads
        step();
        e_rd_req = 1'b1; e_rd_addr = 9'h000;
        @(negedge clk);
        chk("pipe.g0", 128'(e_rd_gnt), 1);
        step();
        e_rd_addr = 9'h00F;
        @(negedge clk);
        chk("pipe.v0", 128'(e_rd_valid), 1);
        chk("pipe.d0", rd_data, line(9'h000));
        step();
        e_rd_addr = 9'h01E;
        @(negedge clk);
        chk("pipe.v1", 128'(e_rd_valid), 1);
        chk("pipe.d1", rd_data, line(9'h00F));
        step();
        e_rd_req = 1'b0;
        @(negedge clk);
        chk("pipe.v2", 128'(e_rd_valid), 1);
        chk("pipe.d2", rd_data, line(9'h01E));
        step();
        @(negedge clk);
        chk("pipe.v3", 128'(e_rd_valid), 0);

        // Reset right after a read grant
        step();
        h_rd_req = 1'b1; h_rd_addr = 9'h055;
        @(negedge clk);
        chk("mrst.g", 128'(h_rd_gnt), 1);
        step();
        rst_n = 1'b0;
        e_wr_req = 1'b1; e_wr_addr = 9'h077; e_wr_data = 64'h3;
        @(negedge clk);
        chk_idle("mrst");
        step();
        h_rd_req = 1'b0; e_wr_req = 1'b0;
        @(negedge clk);
        chk_idle("mrst2");
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("post.hv", 128'(h_rd_valid), 0);
        chk("post.ev", 128'(e_rd_valid), 0);
        step();
        e_rd_req = 1'b1; e_rd_addr = 9'h0AA;
        @(negedge clk);
        chk("post.g", 128'(e_rd_gnt), 1);
        chk("post.ar", 128'(sram_addr_r), 128'h0AA);
        step();
        e_rd_req = 1'b0;
        @(negedge clk);
        chk("post.v", 128'(e_rd_valid), 1);
        chk("post.hv2", 128'(h_rd_valid), 0);
        chk("post.d", rd_data, line(9'h0AA));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_sram_arbiter.md
# conv_sram_arbiter

Arbitrates the conv subsystem's single-read-port / single-write-port result SRAM (9-bit address, 128-bit read line, 64-bit write word) between two requesters: the host side (ICB slave, loading image/filter lines and reading results) and the convolution engine sequencer (image/filter fetch, result write-back). The engine has priority. A per-port starvation counter guarantees the host forward progress unless the engine holds the port exclusively. The block sits between the ICB slave / conv sequencer and the SRAM macro.

## Interface
Parameters:
- ADDR_WIDTH, 9, SRAM address width
- RD_WIDTH, 128, read line width (16 bytes)
- WR_WIDTH, 64, write word width (4 x 16-bit conv results)
- MAX_WAIT, 4, consecutive denied host cycles before the host is forced a grant (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- eng_excl  in  1  engine exclusive mode; disables host starvation promotion on both ports
- h_rd_req / e_rd_req  in  1  host / engine read request
- h_rd_addr / e_rd_addr  in  ADDR_WIDTH  read address
- h_rd_gnt / e_rd_gnt  out  1  read granted this cycle
- h_rd_valid / e_rd_valid  out  1  read data valid for that requester
- rd_data  out  RD_WIDTH  read data, shared by both requesters, qualified by *_rd_valid
- h_wr_req / e_wr_req  in  1  host / engine write request
- h_wr_addr / e_wr_addr  in  ADDR_WIDTH  write address
- h_wr_data / e_wr_data  in  WR_WIDTH  write data
- h_wr_gnt / e_wr_gnt  out  1  write granted (performed) this cycle
- sram_re, sram_addr_r  out  1, ADDR_WIDTH  SRAM read enable and address
- sram_dout  in  RD_WIDTH  SRAM read data, valid the cycle after sram_re
- sram_we, sram_addr_w, sram_din  out  1, ADDR_WIDTH, WR_WIDTH  SRAM write enable, address and data
- h_starve_evt  out  1  one-cycle pulse when a forced host grant occurs on either port

## Operation
- Read and write ports are arbitrated independently with identical logic and may both grant in the same cycle.
- Per port, the winner is:
  - Only one request asserted: that requester.
  - Both asserted: the engine, unless wait_cnt == MAX_WAIT and eng_excl == 0, in which case the host.
  - Neither asserted: no grant.
- wait_cnt (4 bits, per port) behaviour:
  - +1 on each cycle with a host request that is not granted.
  - Saturates at MAX_WAIT.
  - Cleared on a host grant.
  - Holds when the host is not requesting.
  - Does not increment while eng_excl == 1; a value already at MAX_WAIT is held until eng_excl falls.
- Grants are combinational from the requests and wait_cnt. Requesters hold req and addr/data stable until their gnt is seen.
- sram_re = any read grant; sram_addr_r = winner's address, or 0 when idle.
- sram_we = any write grant; sram_addr_w and sram_din = winner's values, or 0 when idle.
- Read return:
  - A registered owner tag (valid + host/engine) captures the read winner.
  - The next cycle, the matching *_rd_valid is high, and rd_data = sram_dout unmodified.
- No read/write forwarding. A read and a write granted in the same cycle to the same address return the old SRAM contents. Ordering is the requesters' responsibility.
- h_starve_evt pulses when the host wins while the engine is also requesting.

## Timing
- Reset values (asynchronous): wait_cnt = 0, owner tag invalid. All outputs are 0: gnt, rd_valid, rd_data, sram_re/we/addr/din, h_starve_evt.
- Grant latency: 0 cycles (same cycle as req).
- Write: takes effect at the clock edge ending the grant cycle.
- Read: *_rd_valid exactly 1 cycle after the grant.
- Throughput: back-to-back reads are pipelined, one grant per cycle; the owner tag updates every cycle.
- Reset asserted mid-transaction: a pending rd_valid is dropped and never issued after reset release.
- eng_excl changes take effect combinationally in the same cycle.

## Structure
- Shared package conv_pkg:
  - CONV_ADDR_WIDTH, CONV_RD_WIDTH, CONV_WR_WIDTH constants.
  - Owner encoding OWN_HOST = 1'b0, OWN_ENG = 1'b1.
- Sub-module conv_arb_port:
  - Two-requester priority arbiter with starvation counter, parameterised by MAX_WAIT.
  - Instantiated once for the read port and once for the write port.
  - Top level adds the address/data muxes, the read owner tag and the starve pulse OR.

## Test plan
- Solo reads: h_rd_req with addr 0x0F0 -> h_rd_gnt in the same cycle; next cycle h_rd_valid = 1, e_rd_valid = 0, rd_data = SRAM line at 0x0F0.
- Contention with MAX_WAIT = 4: both read requests held continuously -> engine granted in cycles 0–3, host in cycle 4 with h_starve_evt = 1, then engine again; wait_cnt is 0 after the host grant.
- eng_excl = 1 with both write requests held for 20 cycles -> e_wr_gnt on every cycle and h_wr_gnt never. After eng_excl falls -> host granted on the very next contention cycle, since the counter was already saturated.
- Simultaneous read and write to the same address 0x180 (old data A, written B) -> rd_data = A; a read of 0x180 the next cycle returns B.
- Pipelined reads: engine reads 0x000, 0x00F, 0x01E on consecutive cycles -> e_rd_valid high for 3 consecutive cycles, each carrying the data in order.
- rst_n asserted the cycle after a read grant -> no rd_valid ever appears. All outputs are 0 during reset, and the first request after release is granted normally.
